elevator_request_scheduler: RTL

- Upstream stage of the Elevator controller: latches hall (floor) and cabin button presses into a pending-request bitmap and selects the next target floor with a SCAN policy (keep direction while requests remain ahead).
- Drives the controller's target-floor input, requests a door-open dwell at each served floor, and clears a request once it has been served.
- Consumes the same floor-number press encoding and `position` feedback the controller uses.

---
 rtl/elevator_pkg.sv | 21 ++
 rtl/elevator_request_scheduler_pending_search.sv | 43 ++++
 rtl/elevator_request_scheduler.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator request scheduler.
// Optional served-stop counter in the scheduler top is enabled by SCHED_SERVED_COUNT_EN.
package elevator_pkg;

    localparam int FLOOR_W = 32;
    localparam logic [FLOOR_W-1:0] NO_FLOOR = '0;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_IDLE  = 3'd1,
        ST_UP    = 3'd2,
        ST_DOWN  = 3'd3,
        ST_SERVE = 3'd4
    } sched_state_t;

    // Floors are numbered from 1, so 0 is never a real floor.
    function automatic logic in_range(input logic [FLOOR_W-1:0] v, input int num_floors);
        return (v != NO_FLOOR) && (v <= FLOOR_W'(num_floors));
    endfunction

endpackage

// File: rtl/elevator_request_scheduler_pending_search.sv
// Combinational search of the pending bitmap relative to the cabin position.
// An out-of-range position reports no requests anywhere.
module pending_search
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 8
) (
    input  logic [NUM_FLOORS-1:0] pending_i,
    input  logic [FLOOR_W-1:0]    position_i,
    output logic                  has_above_o,
    output logic                  has_below_o,
    output logic [FLOOR_W-1:0]    nearest_above_o,
    output logic [FLOOR_W-1:0]    nearest_below_o,
    output logic                  at_floor_o
);

    // Descending scan leaves the lowest floor above; ascending scan leaves the highest below.
    always_comb begin
        has_above_o     = 1'b0;
        has_below_o     = 1'b0;
        nearest_above_o = NO_FLOOR;
        nearest_below_o = NO_FLOOR;
        at_floor_o      = 1'b0;
        if (in_range(position_i, NUM_FLOORS)) begin
            for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
                if (pending_i[i] && (FLOOR_W'(i + 1) > position_i)) begin
                    has_above_o     = 1'b1;
                    nearest_above_o = FLOOR_W'(i + 1);
                end
            end
            for (int i = 0; i < NUM_FLOORS; i++) begin
                if (pending_i[i] && (FLOOR_W'(i + 1) < position_i)) begin
                    has_below_o     = 1'b1;
                    nearest_below_o = FLOOR_W'(i + 1);
                end
                if (pending_i[i] && (FLOOR_W'(i + 1) == position_i)) begin
                    at_floor_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/elevator_request_scheduler.sv
// SCAN request scheduler: latches hall/cabin presses and steers the elevator controller.
// Define SCHED_SERVED_COUNT_EN to add the saturating served_count output.
module elevator_request_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS   = 8,
    parameter int DWELL_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  off_btn,
    input  logic [FLOOR_W-1:0]    position,
    input  logic [FLOOR_W-1:0]    floor_press_event,
    input  logic [FLOOR_W-1:0]    cabin_press_event,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic                  target_valid,
    output logic                  dir_up,
    output logic                  serving,
`ifdef SCHED_SERVED_COUNT_EN
    output logic [15:0]           served_count,
`endif
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int DWELL_W = $clog2(DWELL_CYCLES + 1);
    localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYCLES);

    sched_state_t          state_q, state_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d, set_mask;
    logic [FLOOR_W-1:0]    target_q, target_d;
    logic [FLOOR_W-1:0]    dist_above, dist_below;
    logic                  valid_q, serving_q, dir_q, dir_d;
    logic [DWELL_W-1:0]    dwell_q, dwell_d;
    logic                  pos_ok, reload, enter_serve;
    logic                  has_above, has_below, at_floor;
    logic [FLOOR_W-1:0]    nearest_above, nearest_below;

    pending_search #(
        .NUM_FLOORS (NUM_FLOORS)
    ) u_search (
        .pending_i       (pending_q),
        .position_i      (position),
        .has_above_o     (has_above),
        .has_below_o     (has_below),
        .nearest_above_o (nearest_above),
        .nearest_below_o (nearest_below),
        .at_floor_o      (at_floor)
    );

    always_comb begin
        pos_ok = in_range(position, NUM_FLOORS);
        reload = (state_q == ST_SERVE) && pos_ok &&
                 ((floor_press_event == position) || (cabin_press_event == position));

        // A press for the floor being served only extends the dwell.
        set_mask = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if ((floor_press_event == FLOOR_W'(i + 1)) || (cabin_press_event == FLOOR_W'(i + 1))) begin
                set_mask[i] = 1'b1;
            end
            if ((state_q == ST_SERVE) && (position == FLOOR_W'(i + 1))) begin
                set_mask[i] = 1'b0;
            end
        end

        dist_above  = nearest_above - position;
        dist_below  = position - nearest_below;
        state_d     = state_q;
        pending_d   = pending_q | set_mask;
        target_d    = NO_FLOOR;
        dir_d       = dir_q;
        dwell_d     = dwell_q;
        enter_serve = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (at_floor) begin
                    enter_serve = 1'b1;
                end else if (has_above && (!has_below || (dist_above <= dist_below))) begin
                    state_d  = ST_UP;
                    dir_d    = 1'b1;
                    target_d = nearest_above;
                end else if (has_below) begin
                    state_d  = ST_DOWN;
                    dir_d    = 1'b0;
                    target_d = nearest_below;
                end
            end
            ST_UP: begin
                if (!pos_ok) begin
                    target_d = target_q;
                end else if (at_floor) begin
                    enter_serve = 1'b1;
                end else if (has_above) begin
                    target_d = nearest_above;
                end else if (has_below) begin
                    state_d  = ST_DOWN;
                    dir_d    = 1'b0;
                    target_d = nearest_below;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DOWN: begin
                if (!pos_ok) begin
                    target_d = target_q;
                end else if (at_floor) begin
                    enter_serve = 1'b1;
                end else if (has_below) begin
                    target_d = nearest_below;
                end else if (has_above) begin
                    state_d  = ST_UP;
                    dir_d    = 1'b1;
                    target_d = nearest_above;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVE: begin
                if (reload) begin
                    dwell_d = DWELL_LOAD;
                end else if (dwell_q > DWELL_W'(1)) begin
                    dwell_d = dwell_q - DWELL_W'(1);
                end else begin
                    dwell_d = '0;
                    if (dir_q ? has_above : has_below) begin
                        state_d  = dir_q ? ST_UP : ST_DOWN;
                        target_d = dir_q ? nearest_above : nearest_below;
                    end else if (dir_q ? has_below : has_above) begin
                        dir_d    = ~dir_q;
                        state_d  = dir_q ? ST_DOWN : ST_UP;
                        target_d = dir_q ? nearest_below : nearest_above;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_OFF: begin
                pending_d = '0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Serving a floor wins over a same-cycle press for it.
        if (enter_serve) begin
            state_d  = ST_SERVE;
            dwell_d  = DWELL_LOAD;
            target_d = NO_FLOOR;
            for (int i = 0; i < NUM_FLOORS; i++) begin
                if (position == FLOOR_W'(i + 1)) begin
                    pending_d[i] = 1'b0;
                end
            end
        end

        if (off_btn) begin
            state_d   = ST_OFF;
            pending_d = '0;
            target_d  = NO_FLOOR;
            dwell_d   = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            target_q  <= NO_FLOOR;
            valid_q   <= 1'b0;
            serving_q <= 1'b0;
            dir_q     <= 1'b1;
            dwell_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            target_q  <= target_d;
            valid_q   <= (state_d == ST_UP) || (state_d == ST_DOWN);
            serving_q <= (state_d == ST_SERVE);
            dir_q     <= dir_d;
            dwell_q   <= dwell_d;
        end
    end

`ifdef SCHED_SERVED_COUNT_EN
    logic [15:0] served_q, served_d;

    always_comb begin
        served_d = served_q;
        if (off_btn) begin
            served_d = '0;
        end else if (enter_serve && (served_q != 16'hFFFF)) begin
            served_d = served_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            served_q <= '0;
        end else begin
            served_q <= served_d;
        end
    end

    assign served_count = served_q;
`endif

    assign target_floor = target_q;
    assign target_valid = valid_q;
    assign dir_up       = dir_q;
    assign serving      = serving_q;
    assign pending      = pending_q;

endmodule
